// File: rtl/fas_sched.sv
// Frame/analysis scheduler: double-buffers FIR samples into two 16-sample banks,
// launches the FFT on each full bank and scans the result for the peak-magnitude bin.
module fas_sched (
    input  logic               clk,
    input  logic               rst,
    input  logic               fir_valid,
    input  logic [15:0]        fir_d,
    output logic               frame_we,
    output logic               frame_bank,
    output logic [3:0]         frame_addr,
    output logic [15:0]        frame_wdata,
    output logic               fft_start,
    output logic               fft_bank,
    input  logic               fft_done,
    output logic [3:0]         bin_sel,
    input  logic signed [15:0] bin_re,
    input  logic signed [15:0] bin_im,
    output logic               done,
    output logic [3:0]         freq,
    output logic               ovf
);

    typedef enum logic [1:0] {IDLE, FFT_RUN, SCAN, REPORT} state_t;

    state_t      state, state_nxt;
    logic [1:0]  full, full_nxt;
    logic [3:0]  wr_ptr;
    logic        wr_bank, rd_bank;
    logic [31:0] run_max, cand_max;
    logic [3:0]  run_idx, cand_idx;
    logic signed [31:0] re_sq, im_sq;
    logic [31:0] mag;
    logic        accept, release_bank;

    // Full flags are read from their registered value, so a bank freed this
    // cycle only becomes writable on the next one.
    assign accept       = fir_valid & ~full[wr_bank];
    assign release_bank = (state == FFT_RUN) & fft_done;

    assign frame_we    = rst & accept;
    assign frame_bank  = wr_bank;
    assign frame_addr  = wr_ptr;
    assign frame_wdata = fir_d;
    assign fft_bank    = rd_bank;

    // Each square is at most 2^30, so the sum cannot exceed 32 bits unsigned.
    assign re_sq = bin_re * bin_re;
    assign im_sq = bin_im * bin_im;
    assign mag   = 32'(re_sq) + 32'(im_sq);

    always_comb begin
        cand_max = run_max;
        cand_idx = run_idx;
        if (bin_sel == 4'd0 || mag > run_max) begin
            cand_max = mag;
            cand_idx = bin_sel;
        end
    end

    always_comb begin
        full_nxt = full;
        if (accept && wr_ptr == 4'hF) full_nxt[wr_bank] = 1'b1;
        if (release_bank)             full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fft_start = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    fft_start = 1'b1;
                    state_nxt = FFT_RUN;
                end
            end
            FFT_RUN: if (fft_done) state_nxt = SCAN;
            SCAN:    if (bin_sel == 4'hF) state_nxt = REPORT;
            REPORT: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            full    <= '0;
            bin_sel <= '0;
            freq    <= '0;
            ovf     <= 1'b0;
            run_max <= '0;
            run_idx <= '0;
        end else begin
            full <= full_nxt;
            if (accept) begin
                wr_ptr <= wr_ptr + 4'd1;
                if (wr_ptr == 4'hF) wr_bank <= ~wr_bank;
            end else if (fir_valid) begin
                ovf <= 1'b1;
            end
            if (release_bank) begin
                rd_bank <= ~rd_bank;
                bin_sel <= '0;
            end
            if (state == SCAN) begin
                bin_sel <= bin_sel + 4'd1;
                run_max <= cand_max;
                run_idx <= cand_idx;
                if (bin_sel == 4'hF) freq <= cand_idx;
            end
        end
    end

endmodule

// File: tb/tb_fas_sched.sv
// Directed bench for fas_sched: frame fill, FFT launch, peak scan, overrun,
// same-cycle release, spurious fft_done and mid-scan reset.
module tb_fas_sched;

    logic               clk, rst, fir_valid, fft_done;
    logic [15:0]        fir_d;
    logic               frame_we, frame_bank, fft_start, fft_bank, done, ovf;
    logic [3:0]         frame_addr, bin_sel, freq;
    logic [15:0]        frame_wdata;
    logic signed [15:0] bin_re, bin_im;
    logic signed [15:0] bre [16];
    logic signed [15:0] bim [16];

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    logic saw_done;

    fas_sched dut (
        .clk(clk), .rst(rst), .fir_valid(fir_valid), .fir_d(fir_d),
        .frame_we(frame_we), .frame_bank(frame_bank), .frame_addr(frame_addr),
        .frame_wdata(frame_wdata), .fft_start(fft_start), .fft_bank(fft_bank),
        .fft_done(fft_done), .bin_sel(bin_sel), .bin_re(bin_re), .bin_im(bin_im),
        .done(done), .freq(freq), .ovf(ovf)
    );

    // FFT result memory model, addressed by the block's bin_sel
    assign bin_re = bre[bin_sel];
    assign bin_im = bim[bin_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bins();
        for (int k = 0; k < 16; k++) begin
            bre[k] = '0;
            bim[k] = '0;
        end
    endtask

    initial begin
        rst = 1'b0; fir_valid = 1'b1; fir_d = 16'h1234; fft_done = 1'b0;
        clear_bins();
        #12;
        chk("rst_frame_we", frame_we, 0);
        chk("rst_fft_start", fft_start, 0);
        chk("rst_done", done, 0);
        chk("rst_freq", freq, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_bin_sel", bin_sel, 0);
        chk("rst_addr", frame_addr, 0);
        chk("rst_bank", frame_bank, 0);
        fir_valid = 1'b0;
        rst = 1'b1;

        // 16 contiguous samples into bank 0
        cyc();
        for (int i = 0; i < 16; i++) begin
            fir_valid = 1'b1; fir_d = 16'(i);
            #1;
            chk("fill_we", frame_we, 1);
            chk("fill_addr", frame_addr, 32'(i));
            chk("fill_bank", frame_bank, 0);
            chk("fill_wdata", frame_wdata, 32'(i));
            cyc();
        end
        fir_valid = 1'b0;
        #1;
        chk("launch_start", fft_start, 1);
        chk("launch_bank", fft_bank, 0);
        cyc();
        chk("run_start_low", fft_start, 0);
        chk("run_bank_stable", fft_bank, 0);

        // bins 1 and 15 tie at 0x10000; lowest index wins
        bre[1] = 16'sh0100; bre[15] = 16'sh0100;
        fft_done = 1'b1;
        cyc();
        fft_done = 1'b0;
        chk("scan_bin0", bin_sel, 0);
        for (int k = 0; k < 15; k++) cyc();
        chk("scan_bin15", bin_sel, 15);
        chk("scan_no_done", done, 0);
        cyc();
        chk("report_done", done, 1);
        chk("report_freq", freq, 1);
        cyc();
        chk("done_one_cycle", done, 0);
        chk("freq_hold", freq, 1);

        // fft_done while IDLE is ignored
        fft_done = 1'b1;
        cyc();
        fft_done = 1'b0;
        cyc(); cyc();
        chk("idle_done_binsel", bin_sel, 0);
        chk("idle_done_nodone", done, 0);
        chk("idle_done_nostart", fft_start, 0);

        // overrun: 48 samples, no fft_done
        rst = 1'b0; #1; rst = 1'b1;
        cyc();
        for (int i = 0; i < 48; i++) begin
            fir_valid = 1'b1; fir_d = 16'(16'h0100 + i);
            #1;
            chk("ovr_we", frame_we, (i < 32) ? 1 : 0);
            if (i < 32) begin
                chk("ovr_addr", frame_addr, 32'(i % 16));
                chk("ovr_bank", frame_bank, (i < 16) ? 0 : 1);
            end
            chk("ovr_flag", ovf, (i > 32) ? 1 : 0);
            cyc();
        end
        fir_valid = 1'b0;
        cyc(); cyc(); cyc();
        chk("ovf_sticky", ovf, 1);
        chk("ovr_run_bank", fft_bank, 0);

        // release bank 0 in the same cycle a sample targets it
        clear_bins();
        bre[5] = -16'sh0200; bre[11] = 16'sh0200;
        bim[9] = 16'sh01C0; bre[12] = 16'sh0100; bim[12] = 16'sh0100;
        fir_valid = 1'b1; fir_d = 16'hAAAA; fft_done = 1'b1;
        #1;
        chk("same_cycle_drop", frame_we, 0);
        cyc();
        fft_done = 1'b0; fir_d = 16'hBBBB;
        #1;
        chk("post_release_we", frame_we, 1);
        chk("post_release_addr", frame_addr, 0);
        chk("post_release_bank", frame_bank, 0);
        chk("post_release_wdata", frame_wdata, 32'hBBBB);
        cyc();
        fir_valid = 1'b0;
        chk("scan2_bin1", bin_sel, 1);
        for (int k = 0; k < 14; k++) cyc();
        cyc();
        chk("report2_done", done, 1);
        chk("report2_freq", freq, 5);
        cyc();
        chk("relaunch_start", fft_start, 1);
        chk("relaunch_bank", fft_bank, 1);
        cyc();

        // reset during scan at bin 7
        fft_done = 1'b1;
        cyc();
        fft_done = 1'b0;
        for (int k = 0; k < 7; k++) cyc();
        chk("pre_rst_bin7", bin_sel, 7);
        rst = 1'b0;
        #1;
        chk("mid_rst_bin_sel", bin_sel, 0);
        chk("mid_rst_freq", freq, 0);
        chk("mid_rst_ovf", ovf, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_start", fft_start, 0);
        cyc();
        rst = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (done) saw_done = 1'b1;
        end
        chk("post_rst_no_done", saw_done, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
